mul_arbiter: RTL
================

// Module: mul_arbiter
// PURPOSE
//  Shares one mul_unit between two requesters: port 0 = integer pipeline, port 1 = secondary issue port.
//  - Round-robin arbitration.
//  - Holds operands stable for the whole multiply.
//  - Captures the one-cycle done result and buffers it until the consumer accepts it.
//  - Propagates per-requester kills.
//  - Sits between the issue ports and mul_unit; response goes to writeback.
// PARAMETERS
//  DATA_W  64  operand/result width (must match mul_unit)
//  TAG_W   6   opaque requester tag, returned with the result
// PORTS
//  clk_i          in   1       clock, rising edge
//  rst_i          in   1       asynchronous reset, active-high
//  reqN_valid_i   in   1       N=0,1: request valid
//  reqN_ready_o   out  1       N=0,1: request accepted this cycle
//  reqN_func3_i   in   3       N=0,1: MUL/MULH/MULHSU/MULHU encoding
//  reqN_int32_i   in   1       N=0,1: W-form (32-bit) operation
//  reqN_src1_i    in   DATA_W  N=0,1: rs1
//  reqN_src2_i    in   DATA_W  N=0,1: rs2
//  reqN_tag_i     in   TAG_W   N=0,1: tag
//  kill_i         in   2       bit N flushes requester N's in-flight or buffered op
//  mul_request_o  out  1       to mul_unit request_i
//  mul_kill_o     out  1       to mul_unit kill_mul_i
//  mul_func3_o    out  3       to mul_unit func3_i (registered)
//  mul_int32_o    out  1       to mul_unit int_32_i (registered)
//  mul_src1_o     out  DATA_W  to mul_unit src1_i (registered)
//  mul_src2_o     out  DATA_W  to mul_unit src2_i (registered)
//  mul_result_i   in   DATA_W  from mul_unit result_o
//  mul_stall_i    in   1       from mul_unit stall_o
//  mul_done_i     in   1       from mul_unit done_tick_o
//  rsp_valid_o    out  1       result valid
//  rsp_ready_i    in   1       consumer accepts result
//  rsp_id_o       out  1       owning requester
//  rsp_tag_o      out  TAG_W   owning requester's tag
//  rsp_data_o     out  DATA_W  product
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, operand/result regs 0, last_grant=1 (port 0 wins first).
//  - States:
//    - IDLE: ready to the granted port only. Eligible = valid & ~kill_i[N].
//      - Both eligible -> grant ~last_grant.
//      - On accept: latch func3/int32/src1/src2/tag/id; last_grant=id; go ISSUE.
//    - ISSUE: mul_request_o=1.
//      - mul_done_i=1 (32-bit) -> capture mul_result_i; go RESP.
//      - mul_stall_i=1 (64-bit) -> go WAIT.
//    - WAIT: mul_request_o=0; operands held. On mul_done_i -> capture result; go RESP.
//    - RESP: rsp_valid_o=1, rsp_data_o stable. On rsp_ready_i -> go IDLE.
//  - reqN_ready_o is 0 outside IDLE. No accept in the same cycle as a RESP handshake.
//  - Latency from accept at cycle N: MULW rsp_valid_o at N+2; 64-bit ops at N+3.
//  - Operands are driven from registers during ISSUE and WAIT. mul_unit uses func3 in its DONE cycle, so operands must not change before done.
//  - Kill of owner:
//    - ISSUE/WAIT: mul_kill_o=kill_i[id] (combinational); go IDLE; nothing captured; no response.
//    - RESP: drop the buffered result; go IDLE; rsp_valid_o=0 that cycle.
//    - Kill of the non-owner has no effect on the active op.
//  - mul_kill_o is 0 in IDLE and RESP.
//  - func3 1xx is forwarded unchanged; rsp_data_o=0 (mul_unit default).
//  - mul_done_i outside ISSUE/WAIT is ignored. mul_stall_i and mul_done_i both low in ISSUE is a protocol error: stay in ISSUE.
//  - Reset asserted mid-operation: immediate return to IDLE; buffered result discarded.
// TESTING
//  - 64-bit MUL: port 0, src1=-3, src2=7, func3=000 -> mul_request_o 1 cycle; rsp_data_o=64'hFFFF_FFFF_FFFF_FFEB; rsp_valid_o at accept+3.
//  - MULW: port 1, src1=32'h8000_0000, src2=2, int32=1 -> rsp_valid_o at accept+2; rsp_data_o=0; rsp_id_o=1.
//  - Contention: both ports valid every cycle for 4 ops -> grants 0,1,0,1; tags returned in order.
//  - Backpressure: rsp_ready_i low 5 cycles -> rsp_data_o stable; both reqN_ready_o=0 throughout.
//  - Kill in WAIT: kill_i[0] during port-0 MULHU -> mul_kill_o=1 that cycle; no rsp_valid_o; port 1 accepted next cycle.
//  - Reset during ISSUE: rst_i pulse -> all outputs 0; next request completes normally.

Source files
------------

// File: rtl/mul_arbiter.sv
// Round-robin arbiter that shares one mul_unit between two issue ports.
// It holds the operands for the whole multiply and buffers the one-cycle result until writeback accepts it.
module mul_arbiter #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TAG_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [2:0]        req0_func3_i,
    input  logic              req0_int32_i,
    input  logic [DATA_W-1:0] req0_src1_i,
    input  logic [DATA_W-1:0] req0_src2_i,
    input  logic [TAG_W-1:0]  req0_tag_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [2:0]        req1_func3_i,
    input  logic              req1_int32_i,
    input  logic [DATA_W-1:0] req1_src1_i,
    input  logic [DATA_W-1:0] req1_src2_i,
    input  logic [TAG_W-1:0]  req1_tag_i,
    input  logic [1:0]        kill_i,
    output logic              mul_request_o,
    output logic              mul_kill_o,
    output logic [2:0]        mul_func3_o,
    output logic              mul_int32_o,
    output logic [DATA_W-1:0] mul_src1_o,
    output logic [DATA_W-1:0] mul_src2_o,
    input  logic [DATA_W-1:0] mul_result_i,
    input  logic              mul_stall_i,
    input  logic              mul_done_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_id_o,
    output logic [TAG_W-1:0]  rsp_tag_o,
    output logic [DATA_W-1:0] rsp_data_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last_grant;
    logic       elig0;
    logic       elig1;
    logic       grant_id;
    logic       owner_kill;
    logic       accept;
    logic       capture;

    // Round-robin pick; a killed request is never eligible.
    always_comb begin
        elig0      = req0_valid_i & ~kill_i[0];
        elig1      = req1_valid_i & ~kill_i[1];
        grant_id   = (elig0 & elig1) ? ~last_grant : elig1;
        owner_kill = kill_i[rsp_id_o];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        req0_ready_o  = 1'b0;
        req1_ready_o  = 1'b0;
        mul_request_o = 1'b0;
        mul_kill_o    = 1'b0;
        rsp_valid_o   = 1'b0;
        accept        = 1'b0;
        capture       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rst_i) begin
                    req0_ready_o = elig0 & ~grant_id;
                    req1_ready_o = elig1 & grant_id;
                    accept       = elig0 | elig1;
                end
                if (accept) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mul_request_o = 1'b1;
                mul_kill_o    = owner_kill;
                if (owner_kill) begin
                    state_nxt = S_IDLE;
                end else if (mul_done_i) begin
                    capture   = 1'b1;
                    state_nxt = S_RESP;
                end else if (mul_stall_i) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                mul_kill_o = owner_kill;
                if (owner_kill) begin
                    state_nxt = S_IDLE;
                end else if (mul_done_i) begin
                    capture   = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                // A kill of the owner drops the buffered result in the same cycle.
                rsp_valid_o = ~owner_kill;
                if (owner_kill || rsp_ready_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand, ownership and result registers; operands stay frozen until the next accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant  <= 1'b1;
            mul_func3_o <= 3'd0;
            mul_int32_o <= 1'b0;
            mul_src1_o  <= '0;
            mul_src2_o  <= '0;
            rsp_id_o    <= 1'b0;
            rsp_tag_o   <= '0;
            rsp_data_o  <= '0;
        end else begin
            if (accept) begin
                last_grant  <= grant_id;
                rsp_id_o    <= grant_id;
                mul_func3_o <= grant_id ? req1_func3_i : req0_func3_i;
                mul_int32_o <= grant_id ? req1_int32_i : req0_int32_i;
                mul_src1_o  <= grant_id ? req1_src1_i  : req0_src1_i;
                mul_src2_o  <= grant_id ? req1_src2_i  : req0_src2_i;
                rsp_tag_o   <= grant_id ? req1_tag_i   : req0_tag_i;
            end
            if (capture) begin
                rsp_data_o <= mul_result_i;
            end
        end
    end

endmodule
